// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a small LEGv8-style datapath.
// Moore datapath controls, with IRWrite/PCWrite/retire also gated by mem_ready or Zero.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [1:0]  ALUOp,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_RD    = 4'd4;
    localparam logic [3:0] S_WB_MEM    = 4'd5;
    localparam logic [3:0] S_MEM_WR    = 4'd6;
    localparam logic [3:0] S_BRANCH    = 4'd7;
    localparam logic [3:0] S_EXEC_MOVZ = 4'd8;
    localparam logic [3:0] S_WB_ALU    = 4'd9;
    localparam logic [3:0] S_ERROR     = 4'd10;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;

    logic [3:0] r_state;
    logic [3:0] w_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = S_ERROR;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                casez (Op)
                    11'b10001011000, 11'b11001011000,
                    11'b10001010000, 11'b10101010000: w_next = S_EXEC_R;
                    11'b11111000010, 11'b11111000000: w_next = S_MEM_ADDR;
                    11'b10110100???:                  w_next = S_BRANCH;
                    11'b110100101??:                  w_next = S_EXEC_MOVZ;
                    default:                          w_next = S_ERROR;
                endcase
            end
            S_EXEC_R:    w_next = S_WB_ALU;
            S_EXEC_MOVZ: w_next = S_WB_ALU;
            S_WB_ALU:    w_next = S_FETCH;
            S_MEM_ADDR:  w_next = (Op == OP_LDUR) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_WB_MEM:    w_next = S_FETCH;
            S_MEM_WR:    w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH:    w_next = S_FETCH;
            S_ERROR:     w_next = S_ERROR;
            default:     w_next = S_ERROR;
        endcase
    end

    // Outputs are qualified by reset so an asserted reset silences them with no clock edge.
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        ALUOp    = 2'b00;
        retire   = 1'b0;
        illegal  = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_EXEC_R: ALUOp = 2'b10;
                S_EXEC_MOVZ: begin
                    ALUSrc = 1'b1;
                    ALUOp  = 2'b01;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MEM_ADDR: begin
                    ALUSrc  = 1'b1;
                    Reg2Loc = 1'b1;
                end
                S_MEM_RD: MemRead = 1'b1;
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    retire   = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    Reg2Loc  = 1'b1;
                    ALUSrc   = 1'b1;
                    retire   = mem_ready;
                end
                S_BRANCH: begin
                    Reg2Loc = 1'b1;
                    ALUOp   = 2'b01;
                    Branch  = 1'b1;
                    PCSrc   = 1'b1;
                    PCWrite = Zero;
                    retire  = 1'b1;
                end
                S_ERROR: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and output-vector checks per scenario.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] Op = 11'd0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
    logic        MemRead, MemWrite, Branch, retire, illegal;
    logic [1:0]  ALUOp;
    logic [3:0]  state;

    int n_cmp = 0;
    int n_mis = 0;

    // Output vector: IRWrite PCWrite PCSrc Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0] retire illegal
    localparam logic [13:0] O_NONE     = 14'b00000000000000;
    localparam logic [13:0] O_F_RDY    = 14'b11000001000000;
    localparam logic [13:0] O_F_WAIT   = 14'b00000001000000;
    localparam logic [13:0] O_EXR      = 14'b00000000001000;
    localparam logic [13:0] O_WBALU    = 14'b00000010000010;
    localparam logic [13:0] O_MOVZ     = 14'b00001000000100;
    localparam logic [13:0] O_MADDR    = 14'b00011000000000;
    localparam logic [13:0] O_MRD      = 14'b00000001000000;
    localparam logic [13:0] O_WBMEM    = 14'b00000110000010;
    localparam logic [13:0] O_MWR_WAIT = 14'b00011000100000;
    localparam logic [13:0] O_MWR_RDY  = 14'b00011000100010;
    localparam logic [13:0] O_BR_T     = 14'b01110000010110;
    localparam logic [13:0] O_BR_NT    = 14'b00110000010110;
    localparam logic [13:0] O_ERR      = 14'b00000000000001;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .retire(retire),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [13:0] obs();
        return {IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, Branch, ALUOp, retire, illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        Op = 11'b10001011000;
        repeat (3) tick();
        #1;
        n_cmp++;
        if (state !== 4'd0) begin
            n_mis++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        n_cmp++;
        if (obs() !== O_NONE) begin
            n_mis++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), O_NONE);
        end
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== O_F_WAIT) begin
            n_mis++;
            $display("FAIL reset_release_fetch: got %b expected %b", obs(), O_F_WAIT);
        end
    endtask

    task automatic test_add();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd2, 4'd9};
        logic [13:0] ex [4] = '{O_F_RDY, O_NONE, O_EXR, O_WBALU};
        Op = 11'b10001011000;
        Zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            if (i >= 2) Op = 11'b00000000000;
            #1;
            n_cmp++;
            if (state !== st[i]) begin
                n_mis++;
                $display("FAIL add_state[%0d]: got %0d expected %0d", i, state, st[i]);
            end
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_mis++;
                $display("FAIL add_out[%0d]: got %b expected %b", i, obs(), ex[i]);
            end
            tick();
        end
        Zero = 1'b0;
        n_cmp++;
        if (state !== 4'd0) begin
            n_mis++;
            $display("FAIL add_return: got %0d expected 0", state);
        end
    endtask

    task automatic test_movz();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd8, 4'd9};
        logic [13:0] ex [4] = '{O_F_RDY, O_NONE, O_MOVZ, O_WBALU};
        Op = 11'b11010010110;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (state !== st[i]) begin
                n_mis++;
                $display("FAIL movz_state[%0d]: got %0d expected %0d", i, state, st[i]);
            end
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_mis++;
                $display("FAIL movz_out[%0d]: got %b expected %b", i, obs(), ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_ldur_wait();
        logic [3:0]  st  [7] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [13:0] ex  [7] = '{O_F_RDY, O_NONE, O_MADDR, O_MRD, O_MRD, O_MRD, O_WBMEM};
        Op = 11'b11111000010;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            n_cmp++;
            if (state !== st[i]) begin
                n_mis++;
                $display("FAIL ldur_state[%0d]: got %0d expected %0d", i, state, st[i]);
            end
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_mis++;
                $display("FAIL ldur_out[%0d]: got %b expected %b", i, obs(), ex[i]);
            end
            tick();
        end
        n_cmp++;
        if (state !== 4'd0) begin
            n_mis++;
            $display("FAIL ldur_return: got %0d expected 0", state);
        end
    endtask

    task automatic test_stur();
        logic [3:0]  st  [5] = '{4'd0, 4'd1, 4'd3, 4'd6, 4'd6};
        logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [13:0] ex  [5] = '{O_F_RDY, O_NONE, O_MADDR, O_MWR_WAIT, O_MWR_RDY};
        Op = 11'b11111000000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            n_cmp++;
            if (state !== st[i]) begin
                n_mis++;
                $display("FAIL stur_state[%0d]: got %0d expected %0d", i, state, st[i]);
            end
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_mis++;
                $display("FAIL stur_out[%0d]: got %b expected %b", i, obs(), ex[i]);
            end
            tick();
        end
        n_cmp++;
        if (state !== 4'd0) begin
            n_mis++;
            $display("FAIL stur_return: got %0d expected 0", state);
        end
    endtask

    task automatic test_cbz(input logic zero_in);
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd7};
        logic [13:0] ex [3];
        ex = '{O_F_RDY, O_NONE, (zero_in ? O_BR_T : O_BR_NT)};
        Op = 11'b10110100000;
        Zero = zero_in;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (state !== st[i]) begin
                n_mis++;
                $display("FAIL cbz%0d_state[%0d]: got %0d expected %0d", zero_in, i, state, st[i]);
            end
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_mis++;
                $display("FAIL cbz%0d_out[%0d]: got %b expected %b", zero_in, i, obs(), ex[i]);
            end
            tick();
        end
        n_cmp++;
        if (state !== 4'd0) begin
            n_mis++;
            $display("FAIL cbz%0d_return: got %0d expected 0", zero_in, state);
        end
        Zero = 1'b0;
    endtask

    task automatic test_fetch_stall();
        logic [3:0]  st  [9] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd9};
        logic        rdy [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [13:0] ex  [9] = '{O_F_WAIT, O_F_WAIT, O_F_WAIT, O_F_WAIT, O_F_WAIT,
                                 O_F_RDY, O_NONE, O_EXR, O_WBALU};
        Op = 11'b10101010000;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            n_cmp++;
            if (state !== st[i]) begin
                n_mis++;
                $display("FAIL stall_state[%0d]: got %0d expected %0d", i, state, st[i]);
            end
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_mis++;
                $display("FAIL stall_out[%0d]: got %b expected %b", i, obs(), ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        Op = 11'b00000000000;
        mem_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            Op = (i % 3 == 0) ? 11'b10001011000 : 11'b00000000000;
            #1;
            n_cmp++;
            if (state !== 4'd10 || obs() !== O_ERR) begin
                n_mis++;
                $display("FAIL illegal_hold[%0d]: got state %0d out %b expected 10 %b",
                         i, state, obs(), O_ERR);
            end
            tick();
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            n_mis++;
            $display("FAIL illegal_reset: got state %0d illegal %b expected 0 0", state, illegal);
        end
        tick();
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0 || obs() !== O_F_WAIT) begin
            n_mis++;
            $display("FAIL illegal_recover: got state %0d out %b expected 0 %b",
                     state, obs(), O_F_WAIT);
        end
        tick();
    endtask

    task automatic test_reset_mid_store();
        logic saw_retire;
        saw_retire = 1'b0;
        Op = 11'b11111000000;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd6 || MemWrite !== 1'b1) begin
            n_mis++;
            $display("FAIL midstore_entry: got state %0d MemWrite %b expected 6 1", state, MemWrite);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0 || MemWrite !== 1'b0 || retire !== 1'b0) begin
            n_mis++;
            $display("FAIL midstore_async: got state %0d MemWrite %b retire %b expected 0 0 0",
                     state, MemWrite, retire);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (retire) saw_retire = 1'b1;
            tick();
        end
        n_cmp++;
        if (saw_retire !== 1'b0 || obs() !== O_NONE) begin
            n_mis++;
            $display("FAIL midstore_quiet: got retire_seen %b out %b expected 0 %b",
                     saw_retire, obs(), O_NONE);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (state !== 4'd0 || obs() !== O_F_RDY) begin
            n_mis++;
            $display("FAIL midstore_refetch: got state %0d out %b expected 0 %b",
                     state, obs(), O_F_RDY);
        end
        tick();
        n_cmp++;
        if (state !== 4'd1) begin
            n_mis++;
            $display("FAIL midstore_decode: got %0d expected 1", state);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_movz();
        test_ldur_wait();
        test_stur();
        test_cbz(1'b1);
        test_cbz(1'b0);
        test_fetch_stall();
        test_illegal();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
